// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, response and ALU-side signals of the shared ALU arbiter
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 2
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OP_W-1:0]  req0_op;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OP_W-1:0]  req1_op;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;

  logic [WIDTH-1:0] alu_src_a;
  logic [WIDTH-1:0] alu_src_b;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  alu_result, alu_zero,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    output alu_src_a, alu_src_b, alu_op, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output alu_result, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
    input  alu_src_a, alu_src_b, alu_op, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 2
) (
  input  logic clk,
  input  logic reset_n,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_owner;
  logic             r_busy;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_result0;
  logic [WIDTH-1:0] r_result1;
  logic             r_zero0;
  logic             r_zero1;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;

  logic w_any_valid;
  logic w_sel;
  logic w_fire;
  logic w_owner_ready;

  assign w_any_valid   = bus.req0_valid | bus.req1_valid;
  // On a tie the requester that was not served last goes next
  assign w_sel         = (bus.req0_valid & bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
  assign w_fire        = (r_state == IDLE) & w_any_valid;
  assign w_owner_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  assign bus.req0_ready  = w_fire & ~w_sel;
  assign bus.req1_ready  = w_fire & w_sel;
  assign bus.rsp0_valid  = r_rsp0_valid;
  assign bus.rsp1_valid  = r_rsp1_valid;
  assign bus.rsp0_result = r_result0;
  assign bus.rsp1_result = r_result1;
  assign bus.rsp0_zero   = r_zero0;
  assign bus.rsp1_zero   = r_zero1;
  assign bus.alu_src_a   = r_a;
  assign bus.alu_src_b   = r_b;
  assign bus.alu_op      = r_op;
  assign bus.busy        = r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_result0    <= '0;
      r_result1    <= '0;
      r_zero0      <= 1'b0;
      r_zero1      <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_owner <= w_sel;
            r_a     <= w_sel ? bus.req1_a  : bus.req0_a;
            r_b     <= w_sel ? bus.req1_b  : bus.req0_b;
            r_op    <= w_sel ? bus.req1_op : bus.req0_op;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Only the owner's response registers move; the other side keeps its last result
          if (r_owner) begin
            r_result1    <= bus.alu_result;
            r_zero1      <= bus.alu_zero;
            r_rsp1_valid <= 1'b1;
          end else begin
            r_result0    <= bus.alu_result;
            r_zero0      <= bus.alu_zero;
            r_rsp0_valid <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (w_owner_ready) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_last_grant <= r_owner;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (add / sub / or, equality Zero flag) between two independent requesters, e.g. a main datapath sequencer and a debug/self-test port.
- Round-robin arbitration; operands latched into issue registers; ALU result and Zero captured into a response register.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Sits between the requesters and the ALU. The ALU stays purely combinational; this block supplies its SrcA/SrcB/ALUOp and samples its ALUResult/Zero.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OP_W, 2, ALU opcode width (00 add, 01 sub, 10 or, 11 unused).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_op  input  OP_W  requester 0 opcode.
- rsp0_valid  output  1  requester 0 result available.
- rsp0_ready  input  1  requester 0 consumes result.
- rsp0_result  output  WIDTH  requester 0 result.
- rsp0_zero  output  1  requester 0 Zero flag (a==b).
- req1_*/rsp1_*  same set as requester 0, for requester 1.
- alu_src_a, alu_src_b  output  WIDTH  to ALU SrcA/SrcB.
- alu_op  output  OP_W  to ALU ALUOp.
- alu_result  input  WIDTH  from ALU ALUResult.
- alu_zero  input  1  from ALU Zero.
- busy  output  1  high when state != IDLE.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. Reset forces:
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - operand, op, result and zero registers = 0.
  - all rsp*_valid = 0; busy = 0.
- FSM states IDLE, ISSUE, RESP.
- IDLE:
  - req*_ready is combinational: asserted only for the selected requester, only in IDLE.
  - Selection: if one valid, pick it. If both valid, pick the one not equal to last_grant.
  - On valid&&ready: latch a, b, op and owner into the issue registers; go to ISSUE.
  - At most one req*_ready is high in any cycle.
- ISSUE (exactly 1 cycle):
  - alu_src_a/alu_src_b/alu_op are driven from the issue registers.
  - Capture alu_result and alu_zero into the response registers at the end of the cycle; go to RESP.
- RESP:
  - rsp<owner>_valid = 1, with result/zero stable; the other rsp*_valid stays 0.
  - Hold until rsp<owner>_ready = 1. On that edge: clear valid, set last_grant = owner, go to IDLE.
  - No new request is accepted during ISSUE or RESP. req*_valid with ready low is a stall: the requester must hold its valid and payload.
- Latency: handshake at edge N -> rsp_valid high from cycle N+2. Peak throughput is one operation per 3 cycles when rsp_ready is tied high.
- ALU outputs always reflect the issue registers; they hold their values outside ISSUE, with no glitching to 0.
- Opcode 11 is passed through unchanged; the response carries whatever the ALU returns (its default 0x12345678). No error flag.
- rsp*_result/rsp*_zero hold their last captured values after valid drops.
- The Zero flag is captured from the ALU regardless of opcode.
- Arithmetic is WIDTH-bit wrap-around in the ALU. The arbiter never modifies data.
- Reset asserted mid-operation (ISSUE or RESP): the operation is discarded, no response is produced, and the block returns to IDLE with the reset values above.

Test Plan:
- Reset, then only req0 valid with a=5, b=3, op=00, rsp0_ready=1 -> req0_ready high in cycle 0; alu_src_a=5/alu_src_b=3 in cycle 1; rsp0_valid with result=8, zero=0 in cycle 2; rsp1_valid never asserted.
- Both requesters valid continuously after reset; req0 (a=7, b=7, op=01), req1 (a=0xF0, b=0x0F, op=10) -> grants alternate 0,1,0,1; rsp0 gives result=0, zero=1; rsp1 gives result=0xFF, zero=0.
- req0 a=0xFFFFFFFF, b=1, op=00 -> result=0x00000000, zero=0; then a=0, b=1, op=01 -> result=0xFFFFFFFF.
- Back-pressure: rsp1_ready low for 5 cycles -> rsp1_valid and result held stable; busy=1; req0 (valid throughout) sees req0_ready=0 until one cycle after rsp1_ready rises.
- op=11 from req1 -> rsp1_result=0x12345678.
- reset_n pulsed low during RESP -> rsp*_valid drops immediately (asynchronous); after release, state=IDLE and requester 0 wins the next tie.
